// File: rtl/as_pack.sv
// ----------------------------------------------------------------------------
// as_pack
// Shared definitions for the JTAG instruction-memory loader.
//   - I-Mem frame geometry (address bits, instruction bits, scan length)
//   - JTAG instruction codes understood by the TAP
//   - tap_state_t: the 16 IEEE 1149.1 TAP states, using the customary
//     4-bit encodings so a logic analyser trace reads like the standard
//   - tap_next(): the TMS transition table
// ----------------------------------------------------------------------------
package as_pack;

    localparam int imem_addr_width = 10;
    localparam int instr_width     = 32;
    // Frame = {addr, data, we}
    localparam int im_scan_length  = imem_addr_width + instr_width + 1;

    localparam logic [7:0] JTAG_IMEM_LOAD = 8'h80;
    localparam logic [7:0] JTAG_IDCODE    = 8'h01;
    localparam logic [7:0] JTAG_BYPASS    = 8'hFF;

    typedef enum logic [3:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PA_DR  = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PA_IR  = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_t;

    // Standard TAP transition table. From any state, five TMS=1 edges
    // land in TLR because every "1" arc moves one step closer to it.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t n;
        case (s)
            TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
            TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
            TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
            TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
            TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
            default:    n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/as_sync_edge.sv
// ----------------------------------------------------------------------------
// as_sync_edge
// Two-flop synchroniser for a slow asynchronous clock-like input, followed by
// an edge detector. Produces single-cycle rise/fall pulses in the i_clk
// domain. The input must stay stable for at least two i_clk periods per
// level for both edges to be seen.
// Ports:
//   i_clk   in  sampling clock
//   i_rst   in  synchronous active-high reset (all flops to 0)
//   i_d     in  asynchronous input
//   o_rise  out one-cycle pulse on a synchronised 0->1 transition
//   o_fall  out one-cycle pulse on a synchronised 1->0 transition
// ----------------------------------------------------------------------------
module as_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/as_jtag_tap_imem.sv
// ----------------------------------------------------------------------------
// as_jtag_tap_imem
// JTAG TAP responder that lets an external host write the instruction memory.
// TCK is oversampled on clk_i, so everything below runs in the clk_i domain.
// Supported instructions: IMEM_LOAD (8'h80), IDCODE (8'h01), anything else
// behaves as BYPASS.
//
// Ports:
//   clk_i        in   core clock, at least 4x TCK
//   rst_i        in   synchronous active-high reset
//   tck_i        in   JTAG clock (asynchronous)
//   trst_i       in   JTAG reset, active-high, synchronised here
//   tms_i        in   JTAG mode select
//   tdi_i        in   JTAG serial data in
//   tdo_o        out  JTAG serial data out, updated on synchronised TCK fall
//   imAddr_o     out  I-Mem write address
//   imData_o     out  I-Mem write data
//   imWe_o       out  I-Mem write strobe
//   o_dbg_state  out  current TAP state (tap_state_t encoding)
//
// I-Mem write interface: imWe_o is a one-cycle strobe with no back-pressure.
// imAddr_o/imData_o are valid whenever imWe_o is high and hold their value
// until the next write (or TAP reset), so the sink just captures on imWe_o.
// ----------------------------------------------------------------------------
module as_jtag_tap_imem
    import as_pack::*;
#(
    parameter int          IR_WIDTH        = 8,
    parameter int          IMEM_ADDR_WIDTH = imem_addr_width,
    parameter int          INSTR_WIDTH     = instr_width,
    parameter logic [31:0] IDCODE_VAL      = 32'h0000_0001
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       tck_i,
    input  logic                       trst_i,
    input  logic                       tms_i,
    input  logic                       tdi_i,
    output logic                       tdo_o,
    output logic [IMEM_ADDR_WIDTH-1:0] imAddr_o,
    output logic [INSTR_WIDTH-1:0]     imData_o,
    output logic                       imWe_o,
    output logic [3:0]                 o_dbg_state
);

    localparam int N = IMEM_ADDR_WIDTH + INSTR_WIDTH + 1;

    // The IDCODE LSB is architecturally 1 regardless of the parameter.
    localparam logic [31:0] IDCODE_FIXED = {IDCODE_VAL[31:1], 1'b1};

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic w_tck_r;
    logic w_tck_f;

    as_sync_edge u_tck_sync (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_d    (tck_i),
        .o_rise (w_tck_r),
        .o_fall (w_tck_f)
    );

    // {trst, tms, tdi}: same two-flop depth as TCK so TMS/TDI line up with
    // the detected TCK edge.
    logic [2:0] r_pin_meta;
    logic [2:0] r_pin_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pin_meta <= 3'b000;
            r_pin_sync <= 3'b000;
        end else begin
            r_pin_meta <= {trst_i, tms_i, tdi_i};
            r_pin_sync <= r_pin_meta;
        end
    end

    logic w_trst;
    logic w_tms;
    logic w_tdi;

    assign w_trst = r_pin_sync[2];
    assign w_tms  = r_pin_sync[1];
    assign w_tdi  = r_pin_sync[0];

    // ------------------------------------------------------------------
    // TAP state machine
    // ------------------------------------------------------------------
    tap_state_t r_state;
    tap_state_t w_next;

    assign w_next = tap_next(r_state, w_tms);

    // rst_i has priority, so a TCK edge coinciding with reset is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_trst) begin
            r_state <= TAP_TLR;
        end else if (w_tck_r) begin
            r_state <= w_next;
        end
    end

    assign o_dbg_state = r_state;

    // ------------------------------------------------------------------
    // Instruction / data registers
    // ------------------------------------------------------------------
    logic [IR_WIDTH-1:0]        r_ir;
    logic [IR_WIDTH-1:0]        r_ir_sh;
    logic [N-1:0]               r_dr_imem;
    logic [31:0]                r_dr_id;
    logic                       r_dr_byp;
    logic [IMEM_ADDR_WIDTH-1:0] r_addr;
    logic [INSTR_WIDTH-1:0]     r_data;
    logic                       r_we;
    logic                       r_tdo;

    logic w_sel_imem;
    logic w_sel_id;
    logic w_dr_out;
    logic w_clear;

    assign w_sel_imem = (r_ir == IR_WIDTH'(JTAG_IMEM_LOAD));
    assign w_sel_id   = (r_ir == IR_WIDTH'(JTAG_IDCODE));

    // Bit presented on TDO while in SH_DR. IMEM_LOAD shifts MSB-first,
    // IDCODE and BYPASS shift LSB-first.
    always_comb begin
        w_dr_out = r_dr_byp;
        if (w_sel_imem) begin
            w_dr_out = r_dr_imem[N-1];
        end else if (w_sel_id) begin
            w_dr_out = r_dr_id[0];
        end
    end

    // Test-Logic-Reset holds every register at its reset value, which also
    // covers a pending trst. Nothing happens in TLR, so holding is
    // equivalent to clearing on entry.
    assign w_clear = w_trst || (r_state == TAP_TLR);

    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_ir      <= IR_WIDTH'(JTAG_IDCODE);
            r_ir_sh   <= '0;
            r_dr_imem <= '0;
            r_dr_id   <= '0;
            r_dr_byp  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_tdo     <= 1'b0;
        end else begin
            r_we <= 1'b0;

            // Actions belong to the state being left on this TCK rise.
            if (w_tck_r) begin
                case (r_state)
                    TAP_CAP_IR: begin
                        r_ir_sh <= IR_WIDTH'(1);
                    end
                    TAP_SH_IR: begin
                        r_ir_sh <= {w_tdi, r_ir_sh[IR_WIDTH-1:1]};
                    end
                    TAP_EX1_IR, TAP_EX2_IR: begin
                        // TMS=1 here enters UPD_IR.
                        if (w_tms) begin
                            r_ir <= r_ir_sh;
                        end
                    end
                    TAP_CAP_DR: begin
                        if (w_sel_imem) begin
                            // Read-back of the last committed write.
                            r_dr_imem <= {r_addr, r_data, 1'b0};
                        end else if (w_sel_id) begin
                            r_dr_id <= IDCODE_FIXED;
                        end else begin
                            r_dr_byp <= 1'b0;
                        end
                    end
                    TAP_SH_DR: begin
                        if (w_sel_imem) begin
                            r_dr_imem <= {r_dr_imem[N-2:0], w_tdi};
                        end else if (w_sel_id) begin
                            r_dr_id <= {w_tdi, r_dr_id[31:1]};
                        end else begin
                            r_dr_byp <= w_tdi;
                        end
                    end
                    TAP_EX1_DR, TAP_EX2_DR: begin
                        // Entering UPD_DR: commit the frame if its we bit is
                        // set. The strobe shows up on the following cycle.
                        if (w_tms && w_sel_imem && r_dr_imem[0]) begin
                            r_addr <= r_dr_imem[N-1 -: IMEM_ADDR_WIDTH];
                            r_data <= r_dr_imem[INSTR_WIDTH:1];
                            r_we   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            if (w_tck_f) begin
                if (r_state == TAP_SH_IR) begin
                    r_tdo <= r_ir_sh[0];
                end else if (r_state == TAP_SH_DR) begin
                    r_tdo <= w_dr_out;
                end else begin
                    r_tdo <= 1'b0;
                end
            end
        end
    end

    assign tdo_o    = r_tdo;
    assign imAddr_o = r_addr;
    assign imData_o = r_data;
    assign imWe_o   = r_we;

endmodule

// File: tb/tb_as_jtag_tap_imem.sv
// ----------------------------------------------------------------------------
// tb_as_jtag_tap_imem
// Drives JTAG sequences into as_jtag_tap_imem and checks TDO streams, TAP
// state and the I-Mem write port. Expected writes are queued when a frame
// with we=1 is shifted and popped by the monitor when imWe_o pulses.
// ----------------------------------------------------------------------------
module tb_as_jtag_tap_imem;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int N  = AW + DW + 1;

    localparam logic [3:0] ST_TLR = 4'hF;
    localparam logic [3:0] ST_RTI = 4'hC;
    localparam logic [31:0] EXP_IDCODE = 32'h0000_0001;

    // ---------------- clock / reset / DUT ----------------
    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          tck_i;
    logic          trst_i;
    logic          tms_i;
    logic          tdi_i;
    logic          tdo_o;
    logic [AW-1:0] imAddr_o;
    logic [DW-1:0] imData_o;
    logic          imWe_o;
    logic [3:0]    o_dbg_state;

    always #5 clk_i = ~clk_i;

    as_jtag_tap_imem #(
        .IR_WIDTH        (8),
        .IMEM_ADDR_WIDTH (AW),
        .INSTR_WIDTH     (DW),
        .IDCODE_VAL      (32'h0000_0001)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tck_i       (tck_i),
        .trst_i      (trst_i),
        .tms_i       (tms_i),
        .tdi_i       (tdi_i),
        .tdo_o       (tdo_o),
        .imAddr_o    (imAddr_o),
        .imData_o    (imData_o),
        .imWe_o      (imWe_o),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] mon_e;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    logic             prev_we = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Write-port monitor: every strobe must match the oldest queued write.
    always @(negedge clk_i) begin
        if (imWe_o === 1'b1) begin
            chk("we_consecutive", 64'(prev_we), 64'd0);
            chk("we_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("we_addr", 64'(imAddr_o), 64'(mon_e[AW+DW-1:DW]));
                chk("we_data", 64'(imData_o), 64'(mon_e[DW-1:0]));
            end
        end
        prev_we = imWe_o;
    end

    // ---------------- driver tasks ----------------
    // One TCK period: fall, hold low 20 ns, rise, sample TDO just before
    // the next fall.
    task automatic tck_step(input logic tms, input logic tdi, output logic tdo_s);
        tck_i = 1'b0;
        tms_i = tms;
        tdi_i = tdi;
        #20;
        tck_i = 1'b1;
        #19;
        tdo_s = tdo_o;
        #1;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk_i);
        #2;
    endtask

    task automatic tap_reset();
        logic s;
        for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0, s);
        settle();
    endtask

    // From TLR/RTI: load an 8-bit instruction, end in RTI.
    task automatic load_ir(input logic [7:0] code);
        logic s;
        tck_step(1'b0, 1'b0, s);
        tck_step(1'b1, 1'b0, s);
        tck_step(1'b1, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        for (int i = 0; i < 8; i++) tck_step(i == 7, code[i], s);
        tck_step(1'b1, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        settle();
    endtask

    // From TLR/RTI: capture, shift len bits, update, end in RTI. pause_at>0
    // detours through EX1/PA/EX2 after that many bits.
    task automatic scan_dr(input logic [63:0] din, input int len, input bit msb_first,
                           input int pause_at, output logic [63:0] dout);
        logic s;
        int   b;
        dout = '0;
        tck_step(1'b0, 1'b0, s);
        tck_step(1'b1, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        for (int i = 0; i < len; i++) begin
            b = msb_first ? (len - 1 - i) : i;
            tck_step((i == len - 1) || (i == pause_at - 1), din[b], s);
            dout[b] = s;
            if (pause_at > 0 && i == pause_at - 1 && i != len - 1) begin
                tck_step(1'b0, 1'b0, s);
                tck_step(1'b0, 1'b0, s);
                tck_step(1'b1, 1'b0, s);
                tck_step(1'b0, 1'b0, s);
            end
        end
        tck_step(1'b1, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        settle();
    endtask

    // IMEM_LOAD frame with read-back check and write-port checks.
    task automatic imem_frame(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic we, input int pause_at);
        logic [63:0] frame;
        logic [63:0] rb;
        logic [63:0] exp_rb;
        frame  = 64'({addr, data, we});
        exp_rb = 64'({m_addr, m_data, 1'b0});
        if (we) exp_q.push_back({addr, data});
        scan_dr(frame, N, 1'b1, pause_at, rb);
        chk("imem_readback", rb, exp_rb);
        if (we) begin
            m_addr = addr;
            m_data = data;
        end
        chk("we_pending", 64'(exp_q.size()), 64'd0);
        chk("imAddr_hold", 64'(imAddr_o), 64'(m_addr));
        chk("imData_hold", 64'(imData_o), 64'(m_data));
    endtask

    // Enter SH_DR from RTI and shift nbits without leaving.
    task automatic partial_shift(input int nbits);
        logic s;
        tck_step(1'b0, 1'b0, s);
        tck_step(1'b1, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        tck_step(1'b0, 1'b0, s);
        for (int i = 0; i < nbits; i++) tck_step(1'b0, 1'($urandom_range(0, 1)), s);
    endtask

    task automatic check_tlr_cleared(input string tag);
        m_addr = '0;
        m_data = '0;
        chk({tag, "_state"}, 64'(o_dbg_state), 64'(ST_TLR));
        chk({tag, "_addr"}, 64'(imAddr_o), 64'd0);
        chk({tag, "_data"}, 64'(imData_o), 64'd0);
        chk({tag, "_we_q"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500us;
        n_errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] d;
        logic [7:0]  pat;
        logic        s;

        rst_i  = 1'b1;
        trst_i = 1'b0;
        tck_i  = 1'b0;
        tms_i  = 1'b1;
        tdi_i  = 1'b0;
        m_addr = '0;
        m_data = '0;
        repeat (4) @(posedge clk_i);
        #2;
        chk("rst_state", 64'(o_dbg_state), 64'(ST_TLR));
        chk("rst_tdo", 64'(tdo_o), 64'd0);
        chk("rst_we", 64'(imWe_o), 64'd0);
        chk("rst_addr", 64'(imAddr_o), 64'd0);
        chk("rst_data", 64'(imData_o), 64'd0);
        rst_i = 1'b0;

        tap_reset();
        chk("tms5_state", 64'(o_dbg_state), 64'(ST_TLR));

        // IMEM_LOAD: write, non-write, read-back, paused frame
        load_ir(8'h80);
        chk("ir_load_state", 64'(o_dbg_state), 64'(ST_RTI));
        imem_frame(10'h004, 32'h01D0_0513, 1'b1, 0);
        imem_frame(10'h3F0, 32'hAAAA_AAAA, 1'b0, 0);
        imem_frame(10'h000, 32'h0000_0000, 1'b0, 0);
        imem_frame(10'h155, 32'hDEAD_BEEF, 1'b1, 20);

        // TLR clears outputs and restores IDCODE
        tap_reset();
        check_tlr_cleared("tlr");
        scan_dr(64'(32'hC3A5_0F1E), 32, 1'b0, 0, d);
        chk("idcode", 64'(d[31:0]), 64'(EXP_IDCODE));

        // BYPASS: explicit code and an undefined code
        load_ir(8'hFF);
        pat = 8'b1011_0010;
        scan_dr(64'(pat), 8, 1'b0, 0, d);
        chk("bypass_ff", 64'(d[7:0]), 64'({pat[6:0], 1'b0}));
        load_ir(8'h5A);
        pat = 8'($urandom_range(0, 255));
        scan_dr(64'(pat), 8, 1'b0, 0, d);
        chk("bypass_undef", 64'(d[7:0]), 64'({pat[6:0], 1'b0}));

        // rst_i after 20 of 43 bits aborts the frame
        load_ir(8'h80);
        imem_frame(10'h2A8, 32'h1234_5678, 1'b1, 0);
        load_ir(8'h80);
        partial_shift(20);
        tck_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        settle();
        check_tlr_cleared("rst_abort");
        load_ir(8'h80);
        imem_frame(10'($urandom_range(0, 1023)), 32'($urandom), 1'b1, 0);

        // trst_i mid-shift
        load_ir(8'h80);
        partial_shift(15);
        trst_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #2;
        trst_i = 1'b0;
        settle();
        check_tlr_cleared("trst_abort");

        // Randomised frames
        load_ir(8'h80);
        for (int k = 0; k < 5; k++) begin
            imem_frame(10'($urandom_range(0, 1023)), 32'($urandom),
                       1'($urandom_range(0, 1)),
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N - 1)) : 0);
        end

        tck_step(1'b0, 1'b0, s);
        settle();
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
